fc_addr_demux_n: RTL and testbench
==================================

FC_ADDR_DEMUX_N -- requirements
Module: fc_addr_demux_n

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of downstream master ports (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; BE width = DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum granted-but-unanswered requests (1..15).
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_i input 1 clock; rst_i input 1 reset, sampled on rising clk_i.
REQ-006 SHALL have slave side: s_req_i in 1, s_add_i in ADDR_WIDTH, s_wen_i in 1 (1=read), s_wdata_i in DATA_WIDTH, s_be_i in BE width, s_gnt_o out 1, s_r_valid_o out 1, s_r_rdata_o out DATA_WIDTH, s_r_err_o out 1.
REQ-007 SHALL have master side, one entry per port: m_req_o out N_PORTS, m_add_o out N_PORTS*ADDR_WIDTH, m_wen_o out N_PORTS, m_wdata_o out N_PORTS*DATA_WIDTH, m_be_o out N_PORTS*BE width, m_gnt_i in N_PORTS, m_r_valid_i in N_PORTS, m_r_rdata_i in N_PORTS*DATA_WIDTH.
REQ-008 SHALL have region map: rgn_start_i in N_PORTS*ADDR_WIDTH, rgn_end_i in N_PORTS*ADDR_WIDTH (exclusive end), quasi-static.

Function
REQ-009 SHALL decode target port as lowest index p with rgn_start[p] <= s_add_i < rgn_end[p] (unsigned); overlapping regions resolve to lowest index.
REQ-010 SHALL forward the request combinationally (zero-cycle) to the target port only: m_req_o[p]=s_req_i when not stalled; all other m_req_o = 0; add/wen/wdata/be broadcast to all ports.
REQ-011 SHALL return s_gnt_o = m_gnt_i[p] of the target port when not stalled, else 0.
REQ-012 SHALL keep a state register {IDLE, BUSY}, a locked port index, and an outstanding counter 0..MAX_OUTSTANDING.
REQ-013 IDLE -> BUSY on a granted handshake; locked port := target. BUSY -> IDLE when the counter reaches 0.
REQ-014 Counter: +1 on handshake (req & gnt), -1 on response; both in the same cycle leaves it unchanged.
REQ-015 SHALL stall (mask req, gnt=0) while BUSY and target != locked port, to keep responses in order.
REQ-016 SHALL stall while counter == MAX_OUTSTANDING, unless a response arrives in the same cycle.
REQ-017 SHALL drive s_r_valid_o/s_r_rdata_o combinationally from m_r_valid_i/m_r_rdata_i of the locked port; responses on other ports are ignored and flagged by a simulation assertion.
REQ-018 Response while counter == 0 SHALL be dropped (no underflow) and flagged by assertion.
REQ-019 s_r_err_o SHALL be 0 for every response routed from a master port.

Reset
REQ-020 On rst_i: state IDLE, counter 0, locked port 0; s_gnt_o, s_r_valid_o, s_r_err_o, m_req_o = 0; s_r_rdata_o = 0.
REQ-021 Reset mid-operation SHALL discard outstanding tracking; late responses arriving after reset are dropped.

Configuration
REQ-022 Macro FC_ADDR_DEMUX_ERR_RESP_EN, when defined: unmapped address is granted the same cycle and answered one cycle later with s_r_valid_o=1, s_r_err_o=1, s_r_rdata_o=32'hBADACCE5 (zero-extended); it occupies the counter and lock as internal port N_PORTS.
REQ-023 Without FC_ADDR_DEMUX_ERR_RESP_EN: unmapped addresses route to port 0; s_r_err_o is tied to 0.

Structure
REQ-024 Package fc_addr_demux_pkg SHALL hold the state enum, the port-index typedef (clog2 of N_PORTS+1), and the error rdata constant.
REQ-025 Address decode SHALL be a combinational sub-module fc_addr_decoder (addr, region map -> hit, index).

Verification
REQ-026 N_PORTS=2, regions [0x1C000000,0x1C008000) and [0x1C008000,0x1C080000); read 0x1C000010 -> only m_req_o[0], data routed back, s_r_err_o=0.
REQ-027 Two granted reads to port 1 (latency 3), then a request to port 0 -> stalled until the second port-1 rvalid, then forwarded the same cycle the counter reaches 0.
REQ-028 MAX_OUTSTANDING=2, slave never returns rvalid -> third request sees s_gnt_o=0; one rvalid arrives with a new request in the same cycle -> granted, counter stays 2.
REQ-029 With the macro defined, read 0x00000000 (unmapped) -> s_gnt_o=1, next cycle s_r_valid_o=1, s_r_err_o=1, rdata 0xBADACCE5; without it -> routed to port 0.
REQ-030 rst_i asserted with 3 outstanding -> next cycle IDLE, counter 0; a stale m_r_valid_i is not propagated.
REQ-031 Overlapping regions for ports 0 and 1 covering 0x100 -> port 0 selected.

Source files
------------

// File: rtl/fc_addr_demux_pkg.sv
// Shared types and constants for the address-decoding request demux.
// Optional error responder is enabled by FC_ADDR_DEMUX_ERR_RESP_EN.
package fc_addr_demux_pkg;

  localparam int MAX_PORTS = 8;
  localparam int IDX_W     = $clog2(MAX_PORTS + 1);
  localparam int CNT_W     = 4;

  typedef logic [IDX_W-1:0] port_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/fc_addr_decoder.sv
// Region decoder: lowest-index region containing the address wins.
// Regions are half-open [start, end) compared unsigned.
module fc_addr_decoder
  import fc_addr_demux_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] rgn_start_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] rgn_end_i,
  output logic                          hit_o,
  output port_idx_t                     idx_o
);

  logic [ADDR_WIDTH-1:0] lo, hi;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    lo    = '0;
    hi    = '0;
    // Walk downwards so the lowest matching index is written last.
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      lo = rgn_start_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      hi = rgn_end_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (addr_i >= lo && addr_i < hi) begin
        hit_o = 1'b1;
        idx_o = port_idx_t'(p);
      end
    end
  end

endmodule

// File: rtl/fc_addr_demux_n.sv
// One-slave to N-master request demux with in-order response tracking.
// FC_ADDR_DEMUX_ERR_RESP_EN adds an internal error port for unmapped addresses.
module fc_addr_demux_n
  import fc_addr_demux_pkg::*;
#(
  parameter int N_PORTS         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                s_req_i,
  input  logic [ADDR_WIDTH-1:0]               s_add_i,
  input  logic                                s_wen_i,
  input  logic [DATA_WIDTH-1:0]               s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]             s_be_i,
  output logic                                s_gnt_o,
  output logic                                s_r_valid_o,
  output logic [DATA_WIDTH-1:0]               s_r_rdata_o,
  output logic                                s_r_err_o,
  output logic [N_PORTS-1:0]                  m_req_o,
  output logic [N_PORTS*ADDR_WIDTH-1:0]       m_add_o,
  output logic [N_PORTS-1:0]                  m_wen_o,
  output logic [N_PORTS*DATA_WIDTH-1:0]       m_wdata_o,
  output logic [N_PORTS*(DATA_WIDTH/8)-1:0]   m_be_o,
  input  logic [N_PORTS-1:0]                  m_gnt_i,
  input  logic [N_PORTS-1:0]                  m_r_valid_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]       m_r_rdata_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]       rgn_start_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]       rgn_end_i
);

`ifdef FC_ADDR_DEMUX_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam port_idx_t ErrPort = port_idx_t'(N_PORTS);
  localparam cnt_t      CntMax  = cnt_t'(MAX_OUTSTANDING);

  logic      hit;
  port_idx_t dec_idx, tgt;

  fc_addr_decoder #(
    .N_PORTS    (N_PORTS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .addr_i      (s_add_i),
    .rgn_start_i (rgn_start_i),
    .rgn_end_i   (rgn_end_i),
    .hit_o       (hit),
    .idx_o       (dec_idx)
  );

  state_e    state_q, state_d;
  port_idx_t lock_q, lock_d;
  cnt_t      cnt_q, cnt_d;
  logic      err_pend_q, err_pend_d;

  logic                  tgt_gnt, lock_rvalid, resp, stall, hs;
  logic [DATA_WIDTH-1:0] lock_rdata;

  always_comb begin
    tgt         = hit ? dec_idx : (ErrEn ? ErrPort : '0);
    tgt_gnt     = ErrEn && (tgt == ErrPort);
    lock_rvalid = ErrEn && (lock_q == ErrPort) && err_pend_q;
    lock_rdata  = (ErrEn && lock_q == ErrPort) ? DATA_WIDTH'(ERR_RDATA) : '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (tgt == port_idx_t'(p)) tgt_gnt = m_gnt_i[p];
      if (lock_q == port_idx_t'(p)) begin
        lock_rvalid = m_r_valid_i[p];
        lock_rdata  = m_r_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Responses with nothing outstanding are dropped, which also
  // discards stragglers that arrive after a reset.
  assign resp  = !rst_i && (cnt_q != '0) && lock_rvalid;
  assign stall = rst_i
              || (state_q == BUSY && tgt != lock_q)
              || (cnt_q == CntMax && !resp);

  assign s_gnt_o     = !stall && tgt_gnt;
  assign hs          = s_req_i && s_gnt_o;
  assign s_r_valid_o = resp;
  assign s_r_rdata_o = resp ? lock_rdata : '0;

`ifdef FC_ADDR_DEMUX_ERR_RESP_EN
  assign s_r_err_o = resp && (lock_q == ErrPort);
`else
  assign s_r_err_o = 1'b0;
`endif

  always_comb begin
    m_req_o = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      m_req_o[p] = s_req_i && !stall && (tgt == port_idx_t'(p));
    end
  end

  assign m_add_o   = {N_PORTS{s_add_i}};
  assign m_wen_o   = {N_PORTS{s_wen_i}};
  assign m_wdata_o = {N_PORTS{s_wdata_i}};
  assign m_be_o    = {N_PORTS{s_be_i}};

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    lock_d  = lock_q;
    unique case (1'b1)
      hs && !resp: cnt_d = cnt_q + cnt_t'(1);
      resp && !hs: cnt_d = cnt_q - cnt_t'(1);
      default:     cnt_d = cnt_q;
    endcase
    if (state_q == IDLE && hs) begin
      state_d = BUSY;
      lock_d  = tgt;
    end else if (state_q == BUSY && cnt_d == '0) begin
      state_d = IDLE;
    end
    err_pend_d = ErrEn && hs && (tgt == ErrPort);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_q     <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      err_pend_q <= err_pend_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (port_idx_t'(p) != lock_q)
          assert (!m_r_valid_i[p])
          else $warning("response on unlocked port %0d ignored", p);
      end
      assert (!(cnt_q == '0 && lock_rvalid))
      else $warning("response with nothing outstanding dropped");
    end
  end
`endif

endmodule

// File: tb/tb_fc_addr_demux_n.sv
// Directed plus random checks of fc_addr_demux_n against a queue model.
// Honours FC_ADDR_DEMUX_ERR_RESP_EN when defined for the build.
module tb_fc_addr_demux_n;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAX_A = 4;
  localparam int MAX_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               s_req, b_req;
  logic [AW-1:0]      s_add;
  logic               s_wen;
  logic [DW-1:0]      s_wdata;
  logic [BW-1:0]      s_be;
  logic [NP-1:0]      m_gnt, m_rvalid, b_rv_in;
  logic [NP*DW-1:0]   m_rdata;
  logic [NP*AW-1:0]   rgn_start, rgn_end;

  logic               a_gnt, a_rvalid, a_err;
  logic [DW-1:0]      a_rdata;
  logic [NP-1:0]      a_mreq, a_mwen;
  logic [NP*AW-1:0]   a_madd;
  logic [NP*DW-1:0]   a_mwdata;
  logic [NP*BW-1:0]   a_mbe;

  logic               b_gnt, b_rvalid, b_err;
  logic [DW-1:0]      b_rdata;
  logic [NP-1:0]      b_mreq, b_mwen;
  logic [NP*AW-1:0]   b_madd;
  logic [NP*DW-1:0]   b_mwdata;
  logic [NP*BW-1:0]   b_mbe;

  fc_addr_demux_n #(
    .N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAX_A)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(s_req), .s_add_i(s_add), .s_wen_i(s_wen),
    .s_wdata_i(s_wdata), .s_be_i(s_be),
    .s_gnt_o(a_gnt), .s_r_valid_o(a_rvalid),
    .s_r_rdata_o(a_rdata), .s_r_err_o(a_err),
    .m_req_o(a_mreq), .m_add_o(a_madd), .m_wen_o(a_mwen),
    .m_wdata_o(a_mwdata), .m_be_o(a_mbe),
    .m_gnt_i(m_gnt), .m_r_valid_i(m_rvalid),
    .m_r_rdata_i(m_rdata),
    .rgn_start_i(rgn_start), .rgn_end_i(rgn_end)
  );

  fc_addr_demux_n #(
    .N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_OUTSTANDING(MAX_B)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(b_req), .s_add_i(s_add), .s_wen_i(s_wen),
    .s_wdata_i(s_wdata), .s_be_i(s_be),
    .s_gnt_o(b_gnt), .s_r_valid_o(b_rvalid),
    .s_r_rdata_o(b_rdata), .s_r_err_o(b_err),
    .m_req_o(b_mreq), .m_add_o(b_madd), .m_wen_o(b_mwen),
    .m_wdata_o(b_mwdata), .m_be_o(b_mbe),
    .m_gnt_i(m_gnt), .m_r_valid_i(b_rv_in),
    .m_r_rdata_i(m_rdata),
    .rgn_start_i(rgn_start), .rgn_end_i(rgn_end)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: queue of target ports for granted, unanswered requests.
  int   pq[$];
  logic err_due = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int p = 0; p < NP; p++) begin
      if (a >= rgn_start[p*AW +: AW] && a < rgn_end[p*AW +: AW])
        return p;
    end
`ifdef FC_ADDR_DEMUX_ERR_RESP_EN
    return NP;
`else
    return 0;
`endif
  endfunction

  task automatic cycle();
    int            tgt;
    logic          busy, rok, stl, eg, eerr;
    logic [NP-1:0] emreq;
    logic [DW-1:0] erd;
    #1;
    tgt  = decode(s_add);
    busy = (pq.size() != 0);
    rok  = 1'b0;
    if (!rst && busy)
      rok = (pq[0] == NP) ? err_due : m_rvalid[pq[0]];
    stl = rst || (busy && tgt != pq[0])
       || (pq.size() == MAX_A && !rok);
    eg  = !stl && ((tgt == NP) ? 1'b1 : m_gnt[tgt]);
    emreq = '0;
    if (!stl && s_req && tgt < NP) emreq[tgt] = 1'b1;
    erd  = '0;
    eerr = 1'b0;
    if (rok) begin
      erd  = (pq[0] == NP) ? 32'hBADACCE5 : m_rdata[pq[0]*DW +: DW];
      eerr = (pq[0] == NP);
    end
    chk("gnt", 64'(a_gnt), 64'(eg));
    chk("mreq", 64'(a_mreq), 64'(emreq));
    chk("rvalid", 64'(a_rvalid), 64'(rok));
    chk("rdata", 64'(a_rdata), 64'(erd));
    chk("rerr", 64'(a_err), 64'(eerr));
    chk("madd", a_madd, {NP{s_add}});
    chk("mwen", 64'(a_mwen), 64'({NP{s_wen}}));
    @(posedge clk);
    if (rst) begin
      pq.delete();
      err_due = 1'b0;
    end else begin
      if (rok) void'(pq.pop_front());
      if (s_req && eg) pq.push_back(tgt);
      err_due = s_req && eg && (tgt == NP);
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    s_req    = 1'b0;
    b_req    = 1'b0;
    m_gnt    = '0;
    m_rvalid = '0;
    b_rv_in  = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && pq.size() != 0; k++) begin
      idle_in();
      if (pq[0] < NP) m_rvalid[pq[0]] = 1'b1;
      m_rdata = {$urandom, $urandom};
      cycle();
    end
    idle_in();
    chk("drain_bound", 64'(pq.size()), 64'd0);
  endtask

  logic [AW-1:0] edges [6] = '{32'h1C000000, 32'h1C007FFF,
    32'h1C008000, 32'h1C07FFFF, 32'h1C080000, 32'h1BFFFFFF};

  initial begin
    rst     = 1'b1;
    idle_in();
    s_add   = '0;
    s_wen   = 1'b1;
    s_wdata = '0;
    s_be    = '1;
    m_rdata = '0;
    rgn_start = {32'h1C008000, 32'h1C000000};
    rgn_end   = {32'h1C080000, 32'h1C008000};
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // Read to port 0, data routed back.
    s_req = 1'b1; s_add = 32'h1C000010; m_gnt = 2'b01;
    #1;
    chk("r026_mreq", 64'(a_mreq), 64'd1);
    cycle();
    idle_in();
    m_rvalid = 2'b01; m_rdata = {32'h0, 32'hCAFE0001};
    #1;
    chk("r026_rdata", 64'(a_rdata), 64'h0000_0000_CAFE_0001);
    cycle();
    idle_in();

    // Two reads to port 1, then a blocked request to port 0.
    s_req = 1'b1; s_add = 32'h1C010000; m_gnt = 2'b11;
    cycle();
    cycle();
    s_add = 32'h1C000020;
    #1;
    chk("r027_stall_gnt", 64'(a_gnt), 64'd0);
    cycle();
    m_rvalid = 2'b10; m_rdata = {32'h11110001, 32'h0};
    cycle();
    m_rdata = {32'h11110002, 32'h0};
    #1;
    chk("r027_last_rv_stall", 64'(a_mreq), 64'd0);
    cycle();
    m_rvalid = 2'b00;
    #1;
    chk("r027_fwd_mreq", 64'(a_mreq), 64'd1);
    cycle();
    drain();

    // Narrow instance: full at two outstanding.
    s_add = 32'h1C010000; m_gnt = 2'b11; b_req = 1'b1;
    #1; chk("r028_g0", 64'(b_gnt), 64'd1); cycle();
    #1; chk("r028_g1", 64'(b_gnt), 64'd1); cycle();
    #1; chk("r028_full_gnt", 64'(b_gnt), 64'd0);
    chk("r028_full_mreq", 64'(b_mreq), 64'd0); cycle();
    b_rv_in = 2'b10;
    #1; chk("r028_rv_gnt", 64'(b_gnt), 64'd1);
    chk("r028_rv_valid", 64'(b_rvalid), 64'd1); cycle();
    b_rv_in = 2'b00;
    #1; chk("r028_still_full", 64'(b_gnt), 64'd0); cycle();
    b_req = 1'b0; b_rv_in = 2'b10;
    #1; chk("r028_drain0", 64'(b_rvalid), 64'd1); cycle();
    #1; chk("r028_drain1", 64'(b_rvalid), 64'd1); cycle();
    idle_in();

    // Reset with three outstanding; late response dropped.
    s_req = 1'b1; s_add = 32'h1C010000; m_gnt = 2'b10;
    cycle(); cycle(); cycle();
    idle_in();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_rvalid = 2'b10; m_rdata = {32'hDEAD0001, 32'h0};
    #1;
    chk("r030_stale", 64'(a_rvalid), 64'd0);
    cycle();
    idle_in();
    s_req = 1'b1; s_add = 32'h1C000040; m_gnt = 2'b01;
    #1;
    chk("r030_idle_gnt", 64'(a_gnt), 64'd1);
    cycle();
    drain();

    // Overlapping regions resolve to the lower index.
    rgn_start = {32'h00000100, 32'h00000000};
    rgn_end   = {32'h00000400, 32'h00000200};
    s_req = 1'b1; s_add = 32'h00000100; m_gnt = 2'b00;
    #1;
    chk("r031_mreq", 64'(a_mreq), 64'd1);
    cycle();
    rgn_start = {32'h1C008000, 32'h1C000000};
    rgn_end   = {32'h1C080000, 32'h1C008000};
    idle_in();

    // Unmapped address.
    s_req = 1'b1; s_add = 32'h00000000;
`ifdef FC_ADDR_DEMUX_ERR_RESP_EN
    #1;
    chk("r029_err_gnt", 64'(a_gnt), 64'd1);
    chk("r029_err_mreq", 64'(a_mreq), 64'd0);
    cycle();
    idle_in();
    #1;
    chk("r029_err_rv", 64'(a_rvalid), 64'd1);
    chk("r029_err_flag", 64'(a_err), 64'd1);
    chk("r029_err_data", 64'(a_rdata), 64'hBADACCE5);
    cycle();
`else
    m_gnt = 2'b01;
    #1;
    chk("r029_p0_mreq", 64'(a_mreq), 64'd1);
    cycle();
`endif
    drain();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      s_req = 1'($urandom_range(0, 1));
      if (sel < 4)
        s_add = 32'h1C000000 + ($urandom & 32'h7FFC);
      else if (sel < 8)
        s_add = 32'h1C008000 + $urandom_range(0, 32'h77FFF);
      else if (sel == 8)
        s_add = edges[$urandom_range(0, 5)];
      else
        s_add = $urandom_range(0, 32'hFFFF);
      s_wen   = 1'($urandom_range(0, 1));
      s_wdata = $urandom;
      s_be    = 4'($urandom);
      m_gnt   = 2'($urandom);
      m_rdata = {$urandom, $urandom};
      m_rvalid = '0;
      if (pq.size() != 0 && pq[0] < NP && $urandom_range(0, 2) == 0)
        m_rvalid[pq[0]] = 1'b1;
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
